// File: rtl/clk_sw_pkg.sv
// Shared types and helpers for the N-way clock switch sequencer.
package clk_sw_pkg;

  // FSM states of the break-before-make sequencer
  typedef enum logic [1:0] {
    STABLE  = 2'd0,
    DISABLE = 2'd1,
    ENABLE  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  // Default gate_ack synchroniser depth
  localparam int SYNC_N_DEF = 2;

  // One-hot decode; callers truncate to their channel count
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/sync_bits.sv
// N-flop synchroniser for a W-bit vector of independent async bits.
module sync_bits #(
  parameter int W = 1,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [N-1:0][W-1:0] pipe;

  // Shift every bit through N flops before anyone looks at it
  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[N-2:0], d};
  end

  assign q = pipe[N-1];

endmodule

// File: rtl/clk_switch_seq.sv
// Break-before-make sequencer driving one-hot enables to N clock gates,
// with request handshake, dead-clock timeout and error status.
module clk_switch_seq
  import clk_sw_pkg::*;
#(
  parameter int NCLK    = 4,
  parameter int SELW    = $clog2(NCLK),
  parameter int RST_SEL = 0,
  parameter int TO_W    = 8,
  parameter int SYNC_N  = SYNC_N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SELW-1:0] sel,
  input  logic            sel_valid,
  output logic            sel_ready,
  input  logic [NCLK-1:0] gate_ack,
  output logic [NCLK-1:0] gate_en,
  output logic [SELW-1:0] cur_sel,
  output logic            busy,
  output logic            err_to,
  output logic            err_range,
  input  logic            err_clr
);

  localparam logic [SELW-1:0] RST_SEL_W = SELW'(RST_SEL);

  logic [NCLK-1:0] ack_s;
  state_t          state, nstate;
  logic [SELW-1:0] tgt, n_tgt, n_cur_sel;
  logic [NCLK-1:0] n_gate_en;
  logic [TO_W-1:0] timer;
  logic            ack_cur, sel_ok, accept, tmo, set_to, n_err_range;

  sync_bits #(.W(NCLK), .N(SYNC_N)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gate_ack),
    .q   (ack_s)
  );

  assign sel_ok = (32'(sel) < NCLK);
  assign accept = sel_valid & sel_ready;
  assign tmo    = (timer == '1);

  // Synchronised ack of the currently selected source (loop avoids an oversized index)
  always_comb begin
    ack_cur = 1'b0;
    for (int i = 0; i < NCLK; i++)
      if (cur_sel == SELW'(i)) ack_cur = ack_s[i];
  end

  // Next-state logic; every output is registered from these values
  always_comb begin
    nstate      = state;
    n_tgt       = tgt;
    n_cur_sel   = cur_sel;
    n_gate_en   = gate_en;
    set_to      = 1'b0;
    n_err_range = 1'b0;
    case (state)
      STABLE: begin
        if (accept) begin
          if (!sel_ok) n_err_range = 1'b1;
          else if (sel != cur_sel) begin
            n_tgt     = sel;
            n_gate_en = '0;
            nstate    = DISABLE;
          end
        end
      end
      DISABLE: begin
        // A dead clock keeps ack high forever; with gate_en already low it cannot glitch
        if (!ack_cur || tmo) begin
          set_to    = ack_cur;
          n_cur_sel = tgt;
          n_gate_en = NCLK'(onehot(32'(tgt)));
          nstate    = ENABLE;
        end
      end
      ENABLE: begin
        // gate_en must actually be driven, so a stale ack right after reset is ignored
        if (ack_cur && (gate_en != '0)) nstate = STABLE;
        else if (tmo) begin
          set_to    = 1'b1;
          n_gate_en = '0;
          nstate    = FAULT;
        end else n_gate_en = NCLK'(onehot(32'(cur_sel)));
      end
      FAULT: begin
        n_gate_en = '0;
        if (accept) begin
          if (!sel_ok) n_err_range = 1'b1;
          else begin
            n_cur_sel = sel;
            n_gate_en = NCLK'(onehot(32'(sel)));
            nstate    = ENABLE;
          end
        end
      end
      default: begin
        n_gate_en = '0;
        nstate    = FAULT;
      end
    endcase
  end

  // State, outputs, sticky error and the per-state saturating timer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ENABLE;
      tgt       <= RST_SEL_W;
      cur_sel   <= RST_SEL_W;
      gate_en   <= '0;
      busy      <= 1'b1;
      sel_ready <= 1'b0;
      err_to    <= 1'b0;
      err_range <= 1'b0;
      timer     <= '0;
    end else begin
      state     <= nstate;
      tgt       <= n_tgt;
      cur_sel   <= n_cur_sel;
      gate_en   <= n_gate_en;
      busy      <= (nstate == DISABLE) || (nstate == ENABLE);
      sel_ready <= !((nstate == DISABLE) || (nstate == ENABLE));
      err_range <= n_err_range;
      if (set_to)       err_to <= 1'b1;
      else if (err_clr) err_to <= 1'b0;
      if (nstate != state) timer <= '0;
      else if (((state == DISABLE) || (state == ENABLE)) && !tmo) timer <= timer + 1'b1;
    end
  end

endmodule
